taus_urng: RTL
==============

TAUS_URNG -- requirements
Module: taus_urng

Interface
REQ-001 SHALL have parameter WARMUP, default 16, meaning the number of generator steps discarded after reset or reseed before any output is produced.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of output buffer entries (power of two, at least 2).
REQ-003 SHALL have ports: clk  input  1  the single clock; rising edge active.
REQ-004 SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: seed_load  input  1  single-cycle pulse that starts a reseed sequence.
REQ-006 SHALL have ports: seed_valid  input  1  qualifies seed_data during a reseed sequence.
REQ-007 SHALL have ports: seed_data  input  32  seed word.
REQ-008 SHALL have ports: u_ready  input  1  the downstream log stage accepts a sample.
REQ-009 SHALL have ports: u_valid  output  1  u0/u1 hold a valid sample.
REQ-010 SHALL have ports: u0  output  48  uniform sample for the log stage.
REQ-011 SHALL have ports: u1  output  16  uniform sample for the cos/sin stage.
REQ-012 SHALL have ports: busy  output  1  high during the SEED or WARM states.

Function
REQ-013 SHALL contain two independent taus88 generators, A and B, each with three 32-bit states s1, s2 and s3.
REQ-014 SHALL advance each generator one step per cycle when enabled, using the following update rules:
- s1 = ((s1 & FFFFFFFE) << 12) ^ (((s1 << 13) ^ s1) >> 19)
- s2 = ((s2 & FFFFFFF8) << 4) ^ (((s2 << 2) ^ s2) >> 25)
- s3 = ((s3 & FFFFFFF0) << 17) ^ (((s3 << 3) ^ s3) >> 11)
- the output of each generator is s1 ^ s2 ^ s3, computed from the new states.
REQ-015 SHALL form each sample as u0 = {outA[31:0], outB[31:16]} and u1 = outB[15:0].
REQ-016 SHALL implement an FSM with states SEED, WARM and RUN.
REQ-017 SHALL, in SEED, accept exactly 6 words on cycles where seed_valid is high, in the order A.s1, A.s2, A.s3, B.s1, B.s2, B.s3, and then enter WARM.
REQ-018 SHALL, during seed loading, replace a word with (word | 00000100) when it is below the minimum for its slot; the minimums are s1 2, s2 8 and s3 16.
REQ-019 SHALL, in WARM, step both generators every cycle for WARMUP cycles without writing the FIFO, and then enter RUN.
REQ-020 SHALL, in RUN, step both generators and write one sample into the FIFO on each cycle where the FIFO is not full; when the FIFO is full, the generators hold.
REQ-021 SHALL drive u_valid from FIFO-not-empty; a sample is popped when u_valid and u_ready are both high, and u0/u1 SHALL be stable while u_valid is high and u_ready is low.
REQ-022 SHALL allow a push and a pop in the same cycle when the FIFO is full, and SHALL keep the occupancy unchanged in that case.
REQ-023 SHALL handle seed_load in any state as follows: flush the FIFO, deassert u_valid on the next cycle, restart the word index at 0 and enter SEED.
REQ-024 SHALL ignore seed_valid outside SEED, and SHALL treat a seed_load pulse during SEED as a restart of the load sequence.
REQ-025 SHALL have a first-sample latency from entering RUN of one cycle, i.e. u_valid is high on the cycle after the first RUN cycle.
REQ-026 SHALL keep busy high in SEED and WARM and low in RUN.

Reset
REQ-027 SHALL, when rst is low, asynchronously load the default seeds:
- A = 12345678, 9ABCDEF0, 0F1E2D3C
- B = 89ABCDEF, 76543210, C3D2E1F0
REQ-028 SHALL, when rst is low, set the FSM to WARM with the warm-up counter at 0, empty the FIFO, drive u_valid=0, u0=0 and u1=0, and drive busy=1.
REQ-029 SHALL, when rst is asserted in the middle of a seed sequence, abandon the partially loaded words and revert to the default seeds.

Structure
REQ-030 SHALL place the following items in a shared package hwng_pkg, for use by the downstream log and cos/sin stages:
- the FSM state encoding
- the default seed constants
- the seed minimum constants
- the U0 width (48) and U1 width (16).
REQ-031 SHALL implement the generator as sub-module taus88_step, instantiated twice; it is a combinational next-state and output function.

Verification
REQ-032 SHALL cover reset release with u_ready=1: busy is high for 16 cycles, then u_valid rises, and the first sample equals the first sample after 16 discarded steps of the C model using the default seeds.
REQ-033 SHALL cover reseeding with seed_load followed by six words of 00000001: the stored states are A.s1 = B.s1 = 00000101 and A.s2 = A.s3 = B.s2 = B.s3 = 00000101, and the output sequence matches the C model seeded with those values.
REQ-034 SHALL cover backpressure with u_ready held at 0 for 10 cycles in RUN: u_valid stays at 1, u0/u1 are unchanged, the FIFO holds 2 entries and the generators hold; after releasing u_ready, the samples continue in sequence with none lost or duplicated.
REQ-035 SHALL cover seed_load asserted while u_valid=1 and u_ready=0: u_valid is 0 on the next cycle and no pre-reseed sample ever appears.
REQ-036 SHALL cover rst asserted low after three of the six seed words have been loaded: the block restarts from the default seeds and the REQ-032 sequence is reproduced.
REQ-037 SHALL cover 10^6 samples taken with random u_ready: the mean of u1 is within 1% of 32767.5 and the sequence matches the C model throughout.

Source files
------------

// File: rtl/hwng_pkg.sv
// Shared definitions for the hardware normal generator: FSM encoding, default seeds,
// seed minimums and sample widths used by the URNG, log and cos/sin stages.
package hwng_pkg;

  localparam int unsigned U0W = 48;
  localparam int unsigned U1W = 16;

  localparam logic [1:0] StSeed = 2'd0;
  localparam logic [1:0] StWarm = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  localparam logic [31:0] SeedA1 = 32'h12345678;
  localparam logic [31:0] SeedA2 = 32'h9ABCDEF0;
  localparam logic [31:0] SeedA3 = 32'h0F1E2D3C;
  localparam logic [31:0] SeedB1 = 32'h89ABCDEF;
  localparam logic [31:0] SeedB2 = 32'h76543210;
  localparam logic [31:0] SeedB3 = 32'hC3D2E1F0;

  localparam logic [31:0] S1Min = 32'd2;
  localparam logic [31:0] S2Min = 32'd8;
  localparam logic [31:0] S3Min = 32'd16;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
  } taus_state_t;

  // Words below the slot minimum would collapse that component to a zero cycle.
  function automatic logic [31:0] seed_fix(input logic [31:0] word, input logic [31:0] min_val);
    return (word < min_val) ? (word | 32'h0000_0100) : word;
  endfunction

endpackage

// File: rtl/taus88_step.sv
// One combinational taus88 step: next component states and the combined output word.
module taus88_step
  import hwng_pkg::*;
(
  input  taus_state_t cur,
  output taus_state_t nxt,
  output logic [31:0] out
);

  always_comb begin
    nxt.s1 = ((cur.s1 & 32'hFFFF_FFFE) << 12) ^ (((cur.s1 << 13) ^ cur.s1) >> 19);
    nxt.s2 = ((cur.s2 & 32'hFFFF_FFF8) << 4)  ^ (((cur.s2 << 2)  ^ cur.s2) >> 25);
    nxt.s3 = ((cur.s3 & 32'hFFFF_FFF0) << 17) ^ (((cur.s3 << 3)  ^ cur.s3) >> 11);
    out    = nxt.s1 ^ nxt.s2 ^ nxt.s3;
  end

endmodule

// File: rtl/taus_urng.sv
// Dual taus88 uniform generator with reseed/warm-up sequencing and a small output FIFO.
module taus_urng
  import hwng_pkg::*;
#(
  parameter int unsigned WARMUP     = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           seed_load,
  input  logic           seed_valid,
  input  logic [31:0]    seed_data,
  input  logic           u_ready,
  output logic           u_valid,
  output logic [U0W-1:0] u0,
  output logic [U1W-1:0] u1,
  output logic           busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned SW = U0W + U1W;

  taus_state_t gen_a_q, gen_a_d, nxt_a;
  taus_state_t gen_b_q, gen_b_d, nxt_b;
  logic [31:0] out_a, out_b;

  logic [1:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] mem_q [FIFO_DEPTH];
  logic [SW-1:0] rd_word;
  logic          full, pop, push, step;

  taus88_step u_gen_a (
    .cur (gen_a_q),
    .nxt (nxt_a),
    .out (out_a)
  );

  taus88_step u_gen_b (
    .cur (gen_b_q),
    .nxt (nxt_b),
    .out (out_b)
  );

  assign u_valid = (wr_ptr_q != rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = u_valid && u_ready;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
  assign u0      = u_valid ? rd_word[SW-1:U1W] : '0;
  assign u1      = u_valid ? rd_word[U1W-1:0] : '0;
  assign busy    = (st_q != StRun);

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    gen_a_d  = gen_a_q;
    gen_b_d  = gen_b_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push     = 1'b0;
    step     = 1'b0;

    if (seed_load) begin
      // Flush wins over any pop or push in the same cycle.
      st_d     = StSeed;
      idx_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      case (st_q)
        StSeed: begin
          if (seed_valid) begin
            case (idx_q)
              3'd0:    gen_a_d.s1 = seed_fix(seed_data, S1Min);
              3'd1:    gen_a_d.s2 = seed_fix(seed_data, S2Min);
              3'd2:    gen_a_d.s3 = seed_fix(seed_data, S3Min);
              3'd3:    gen_b_d.s1 = seed_fix(seed_data, S1Min);
              3'd4:    gen_b_d.s2 = seed_fix(seed_data, S2Min);
              3'd5:    gen_b_d.s3 = seed_fix(seed_data, S3Min);
              default: ;
            endcase
            if (idx_q == 3'd5) begin
              st_d  = StWarm;
              cnt_d = '0;
              idx_d = '0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        StWarm: begin
          step = 1'b1;
          if (cnt_q == CW'(WARMUP - 1)) begin
            st_d  = StRun;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          // A pop frees a slot this cycle, so a full FIFO can still accept.
          if (!full || pop) begin
            push = 1'b1;
            step = 1'b1;
          end
        end
        default: st_d = StWarm;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (step) begin
        gen_a_d = nxt_a;
        gen_b_d = nxt_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gen_a_q  <= '{s1: SeedA1, s2: SeedA2, s3: SeedA3};
      gen_b_q  <= '{s1: SeedB1, s2: SeedB2, s3: SeedB3};
      st_q     <= StWarm;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      gen_a_q  <= gen_a_d;
      gen_b_q  <= gen_b_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {out_a, out_b};
  end

endmodule
